// File: rtl/rv32_prog_loader_if.sv
// rv32_prog_loader_if: byte-stream input and imem/dmem programming port of the loader.
interface rv32_prog_loader_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              imem_w_en;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_data;
   logic              dmem_w_en;
   modport master (
      input  rx_data, rx_valid,
      output rx_ready, imem_addr, imem_data, imem_w_en, dmem_addr, dmem_data, dmem_w_en
   );
   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, imem_addr, imem_data, imem_w_en, dmem_addr, dmem_data, dmem_w_en
   );
endinterface

// File: rtl/rv32_prog_loader.sv
// rv32_prog_loader: framed byte-stream loader writing imem/dmem and holding the core in reset.
// Optional trailing XOR checksum byte enabled by PITO_LOADER_CKSUM_EN.
module rv32_prog_loader #(
   parameter int ADDR_W = 12
) (
   input  logic               rv32_io_clk,
   input  logic               rv32_io_rst_n,
   rv32_prog_loader_if.master bus,
   output logic               program_o,
   output logic               core_rst_n_o,
   output logic               busy_o,
   output logic               err_o
);
   typedef enum logic [3:0] {SYNC, CMD, ADDR0, ADDR1, CNT0, CNT1, DATA, WRITE
`ifdef PITO_LOADER_CKSUM_EN
      , CKSUM
`endif
   } state_t;
`ifdef PITO_LOADER_CKSUM_EN
   localparam state_t FIN = CKSUM;
`else
   localparam state_t FIN = SYNC;
`endif
   state_t            state_q, state_d;
   logic              tgt_q, tgt_d;
   logic [7:0]        lo_q, lo_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        bc_q, bc_d;
   logic [ADDR_W-1:0] ia_q, ia_d, da_q, da_d;
   logic [31:0]       id_q, id_d, dd_q, dd_d;
   logic              iwe_q, iwe_d, dwe_q, dwe_d;
   logic              rdy_q, rdy_d, prog_q, prog_d, crst_q, crst_d, busy_q, busy_d, err_q, err_d;
   logic              acc;
   logic [7:0]        b;
   logic [31:0]       wnext;
   assign acc   = bus.rx_valid && rdy_q;
   assign b     = bus.rx_data;
   assign wnext = {b, word_q[31:8]};
`ifdef PITO_LOADER_CKSUM_EN
   logic [7:0] cs_q, cs_d;
   always_comb begin
      cs_d = cs_q;
      if (acc && state_q == CMD) cs_d = b;
      else if (acc && state_q inside {ADDR0, ADDR1, CNT0, CNT1, DATA}) cs_d = cs_q ^ b;
   end
   always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n)
      if (!rv32_io_rst_n) cs_q <= '0;
      else cs_q <= cs_d;
`endif
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      lo_d    = lo_q;
      wa_d    = wa_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      bc_d    = bc_q;
      ia_d    = ia_q;
      id_d    = id_q;
      da_d    = da_q;
      dd_d    = dd_q;
      iwe_d   = 1'b0;
      dwe_d   = 1'b0;
      prog_d  = prog_q;
      crst_d  = crst_q;
      err_d   = err_q;
      if (state_q == WRITE) begin
         wa_d    = wa_q + ADDR_W'(1);
         cnt_d   = cnt_q - 16'd1;
         state_d = (cnt_q == 16'd1) ? FIN : DATA;
      end else if (acc) begin
         case (state_q)
            SYNC: state_d = (b == 8'hA5) ? CMD : SYNC;
            CMD: begin
               state_d = SYNC;
               if (b == 8'h01 || b == 8'h02) begin
                  tgt_d   = b[1];
                  prog_d  = 1'b1;
                  crst_d  = 1'b0;
                  state_d = ADDR0;
               end else if (b == 8'h03) begin
                  prog_d = 1'b0;
                  crst_d = 1'b1;
               end else err_d = 1'b1;
            end
            ADDR0: begin
               lo_d    = b;
               state_d = ADDR1;
            end
            ADDR1: begin
               wa_d    = ADDR_W'({b, lo_q});
               state_d = CNT0;
            end
            CNT0: begin
               lo_d    = b;
               state_d = CNT1;
            end
            CNT1: begin
               cnt_d   = {b, lo_q};
               bc_d    = 2'd0;
               state_d = ({b, lo_q} == 16'd0) ? FIN : DATA;
            end
            DATA: begin
               word_d = wnext;
               bc_d   = bc_q + 2'd1;
               // the fourth byte lands the word straight into the selected port registers
               if (bc_q == 2'd3) begin
                  state_d = WRITE;
                  ia_d    = tgt_q ? ia_q : wa_q;
                  id_d    = tgt_q ? id_q : wnext;
                  iwe_d   = !tgt_q;
                  da_d    = tgt_q ? wa_q : da_q;
                  dd_d    = tgt_q ? wnext : dd_q;
                  dwe_d   = tgt_q;
               end
            end
`ifdef PITO_LOADER_CKSUM_EN
            CKSUM: begin
               err_d   = err_q | (b != cs_q);
               state_d = SYNC;
            end
`endif
            default: state_d = SYNC;
         endcase
      end
      rdy_d  = state_d != WRITE;
      busy_d = state_d != SYNC;
   end
   always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n)
      if (!rv32_io_rst_n) begin
         state_q <= SYNC;
         tgt_q   <= 1'b0;
         lo_q    <= '0;
         wa_q    <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         bc_q    <= '0;
         ia_q    <= '0;
         id_q    <= '0;
         da_q    <= '0;
         dd_q    <= '0;
         iwe_q   <= 1'b0;
         dwe_q   <= 1'b0;
         rdy_q   <= 1'b1;
         prog_q  <= 1'b0;
         crst_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         lo_q    <= lo_d;
         wa_q    <= wa_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         bc_q    <= bc_d;
         ia_q    <= ia_d;
         id_q    <= id_d;
         da_q    <= da_d;
         dd_q    <= dd_d;
         iwe_q   <= iwe_d;
         dwe_q   <= dwe_d;
         rdy_q   <= rdy_d;
         prog_q  <= prog_d;
         crst_q  <= crst_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   assign bus.rx_ready  = rdy_q;
   assign bus.imem_addr = ia_q;
   assign bus.imem_data = id_q;
   assign bus.imem_w_en = iwe_q;
   assign bus.dmem_addr = da_q;
   assign bus.dmem_data = dd_q;
   assign bus.dmem_w_en = dwe_q;
   assign program_o     = prog_q;
   assign core_rst_n_o  = crst_q;
   assign busy_o        = busy_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_rv32_prog_loader.sv
// tb_rv32_prog_loader: directed plus randomized frames checked against a write-list model.
module tb_rv32_prog_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic program_w, core_rst_n_w, busy_w, err_w;
   int tests = 0;
   int fails = 0;
   int rdy_bad = 0;
   logic [7:0] ck;
   logic exp_prog = 1'b0, exp_crst = 1'b0, exp_err = 1'b0;
   logic [44:0] obs_q[$];
   logic [44:0] exp_q[$];
   logic [31:0] data_q[$];

   always #5 clk = ~clk;

   rv32_prog_loader_if #(.ADDR_W(12)) bus();

   rv32_prog_loader #(.ADDR_W(12)) dut (
      .rv32_io_clk(clk),
      .rv32_io_rst_n(rst_n),
      .bus(bus),
      .program_o(program_w),
      .core_rst_n_o(core_rst_n_w),
      .busy_o(busy_w),
      .err_o(err_w)
   );

   // write monitor: every strobe-high cycle becomes one observed write
   always @(negedge clk) begin
      if (bus.imem_w_en === 1'b1) obs_q.push_back({1'b0, bus.imem_addr, bus.imem_data});
      if (bus.dmem_w_en === 1'b1) obs_q.push_back({1'b1, bus.dmem_addr, bus.dmem_data});
      if ((bus.imem_w_en || bus.dmem_w_en) && bus.rx_ready) rdy_bad++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      tests++;
      assert (obs === req) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (bus.rx_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      assert (n < 16) else begin
         fails++;
         $error("FAIL rx_ready_timeout: observed ready=%b expected 1", bus.rx_ready);
      end
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
   endtask

   task automatic sendc(input logic [7:0] b);
      ck = ck ^ b;
      send(b);
   endtask

   task automatic send_ck(input bit good);
`ifdef PITO_LOADER_CKSUM_EN
      send(good ? ck : ~ck);
      if (!good) exp_err = 1'b1;
`else
      if (!good) exp_err = exp_err;
`endif
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_program"}, 64'(program_w), 64'(exp_prog));
      chk({tag, "_core_rst_n"}, 64'(core_rst_n_w), 64'(exp_crst));
      chk({tag, "_err"}, 64'(err_w), 64'(exp_err));
      chk({tag, "_busy"}, 64'(busy_w), 64'd0);
      chk({tag, "_rdy_during_write"}, 64'(rdy_bad), 64'd0);
   endtask

   task automatic check_writes(input string tag);
      int n;
      repeat (3) @(negedge clk);
      chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   // load frame; words come from data_q when preloaded, otherwise random
   task automatic send_load(input string tag, input logic [7:0] cmd, input logic [15:0] addr,
                            input int n, input bit good);
      logic [31:0] w;
      logic [11:0] a;
      logic [44:0] last;
      last = '0;
      send(8'hA5);
      ck = 8'h00;
      sendc(cmd);
      exp_prog = 1'b1;
      exp_crst = 1'b0;
      sendc(addr[7:0]);
      sendc(addr[15:8]);
      w = 32'(n);
      sendc(w[7:0]);
      sendc(w[15:8]);
      for (int i = 0; i < n; i++) begin
         w = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
         a = 12'((int'(addr) + i) % 4096);
         last = {cmd == 8'h02, a, w};
         exp_q.push_back(last);
         for (int k = 0; k < 4; k++) sendc(w[8*k +: 8]);
      end
      send_ck(good);
      check_writes(tag);
      check_idle(tag);
      if (n > 0)
         chk({tag, "_hold"}, last[44] ? 64'({bus.dmem_addr, bus.dmem_data}) : 64'({bus.imem_addr, bus.imem_data}),
             64'(last[43:0]));
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #12;
      chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
      chk("rst_imem", 64'({bus.imem_addr, bus.imem_data, bus.imem_w_en}), 64'd0);
      chk("rst_dmem", 64'({bus.dmem_addr, bus.dmem_data, bus.dmem_w_en}), 64'd0);
      chk("rst_ctrl", 64'({program_w, core_rst_n_w, busy_w, err_w}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // plan frame: two imem words at 0x010
      data_q.push_back(32'hDEADBEEF);
      data_q.push_back(32'h12345678);
      send_load("imem_plan", 8'h01, 16'h0010, 2, 1'b1);

      send_load("dmem_wrap", 8'h02, 16'h0FFF, 2, 1'b1);

      send(8'hA5);
      chk("pre_run_program", 64'(program_w), 64'd1);
      send(8'h03);
      exp_prog = 1'b0;
      exp_crst = 1'b1;
      chk("run_program", 64'(program_w), 64'd0);
      chk("run_core_rst_n", 64'(core_rst_n_w), 64'd1);
      check_idle("run");

      send(8'hA5);
      ck = 8'h00;
      sendc(8'h01);
      chk("reload_core_rst_n", 64'(core_rst_n_w), 64'd0);
      chk("reload_program", 64'(program_w), 64'd1);
      exp_prog = 1'b1;
      exp_crst = 1'b0;
      for (int i = 0; i < 4; i++) sendc(8'h00);
      send_ck(1'b1);
      check_writes("cnt_zero");
      check_idle("cnt_zero");

      send(8'h00);
      send(8'h13);
      send(8'hA4);
      chk("garbage_busy", 64'(busy_w), 64'd0);
      send(8'hA5);
      chk("sync_busy", 64'(busy_w), 64'd1);
      send(8'h07);
      exp_err = 1'b1;
      check_idle("bad_cmd");
      send_load("after_bad", 8'h01, 16'h0123, 3, 1'b1);

      for (int f = 0; f < 6; f++)
         send_load("rand", 8'($urandom_range(1, 2)), 16'($urandom), $urandom_range(1, 4), 1'b1);

`ifdef PITO_LOADER_CKSUM_EN
      data_q.push_back(32'h44332211);
      send_load("ck_good", 8'h01, 16'h0000, 1, 1'b1);
      data_q.push_back(32'h44332211);
      send_load("ck_bad", 8'h01, 16'h0000, 1, 1'b0);
`endif

      // reset after two of four data bytes
      send(8'hA5);
      send(8'h01);
      send(8'h40);
      send(8'h00);
      send(8'h01);
      send(8'h00);
      send(8'hAA);
      send(8'hBB);
      chk("mid_busy", 64'(busy_w), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rx_ready", 64'(bus.rx_ready), 64'd1);
      chk("mid_rst_imem", 64'({bus.imem_addr, bus.imem_data, bus.imem_w_en}), 64'd0);
      chk("mid_rst_dmem", 64'({bus.dmem_addr, bus.dmem_data, bus.dmem_w_en}), 64'd0);
      chk("mid_rst_ctrl", 64'({program_w, core_rst_n_w, busy_w, err_w}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_prog = 1'b0;
      exp_crst = 1'b0;
      exp_err  = 1'b0;
      check_writes("aborted");
      send_load("after_rst", 8'h02, 16'h0040, 2, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
